fetch_stage: RTL and testbench

- Parametrised instruction-fetch stage; successor to the fixed PC + adder + memory fetch path.
- Owns the PC and issues one request per cycle to a synchronous-read instruction memory (1-cycle latency).
- Buffers responses in a 2-entry skid buffer and presents {pc, instruction} to decode over valid/ready.
- Supports branch/jump redirect with flush, and a sticky misaligned-target fault.

---
 rtl/fetch_pkg.sv | 45 ++++
 rtl/fetch_stage_if.sv | 41 ++++
 rtl/fetch_skid_buffer.sv | 63 ++++++
 rtl/fetch_stage.sv | 157 +++++++++++++++
 tb/tb_fetch_stage.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types, state encodings and helpers for the fetch stage.
// Revision    : 1.0 - initial parametrised fetch stage
// ============================================================================
package fetch_pkg;

    localparam int c_DEFAULT_PC_STEP    = 4;
    localparam int c_DEFAULT_ALIGN_BITS = 2;
    localparam int c_MAX_XLEN           = 64;

    // Named states, kept as an enum for waveform readability.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    // Encoded constants used by the state register itself.
    localparam logic [1:0] c_ST_BOOT  = ST_BOOT;
    localparam logic [1:0] c_ST_RUN   = ST_RUN;
    localparam logic [1:0] c_ST_FAULT = ST_FAULT;

    // One decoded-slot entry at the default 32-bit widths.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // True when any of the low align_bits bits of the target are set.
    function automatic logic is_misaligned(input logic [c_MAX_XLEN-1:0] target,
                                           input int                    align_bits);
        logic r;
        r = 1'b0;
        for (int i = 0; i < c_MAX_XLEN; i++) begin
            if ((i < align_bits) && target[i]) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Instruction-memory and decode-side handshake bundle.
// Revision    : 1.0 - initial parametrised fetch stage
// ============================================================================
interface fetch_stage_if #(
    parameter int XLEN    = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instruction;

    // Fetch-stage side.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instruction
    );

    // Memory / decode side.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instruction
    );
endinterface
`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buffer
// Description : Two-entry FIFO with simultaneous push/pop and flush.
// Revision    : 1.0 - initial parametrised fetch stage
// ============================================================================
module fetch_skid_buffer #(
    parameter int WIDTH = 64
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    input  wire logic             flush,
    output logic      [1:0]       count,
    output logic      [WIDTH-1:0] head
);

    logic [WIDTH-1:0] r_mem [0:1];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // A pop needs data; a push needs space, which a same-cycle pop provides.
    assign w_do_pop  = pop && (r_count != 2'd0);
    assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

    // Pointer and occupancy bookkeeping; flush empties the buffer at once.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch: PC ownership, 1-cycle synchronous memory
//               requests, 2-entry response buffer, redirect and fault.
//               Optional performance counters under macro FETCH_PERF_EN.
// Revision    : 1.0 - initial parametrised fetch stage
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int INSTR_W    = 32,
    parameter int PC_STEP    = c_DEFAULT_PC_STEP,
    parameter int ALIGN_BITS = c_DEFAULT_ALIGN_BITS
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic [XLEN-1:0] initial_address,
    input  wire logic            redirect_valid,
    input  wire logic [XLEN-1:0] redirect_target,
    output logic                 fault,
`ifdef FETCH_PERF_EN
    output logic      [31:0]     perf_fetched,
    output logic      [31:0]     perf_stall,
`endif
    fetch_stage_if.master        bus
);

    localparam int c_ENTRY_W = XLEN + INSTR_W;

    logic [1:0]           r_state;
    logic [XLEN-1:0]      r_pc;
    logic [XLEN-1:0]      r_inflight_pc;
    logic                 r_inflight;
    logic                 r_fault;

    logic                 w_run;
    logic                 w_redirect;
    logic                 w_misaligned;
    logic                 w_out_valid;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_issue;
    logic [2:0]           w_occupancy;
    logic [1:0]           w_count;
    logic [c_ENTRY_W-1:0] w_head;
    logic [XLEN-1:0]      w_head_pc;
    logic [INSTR_W-1:0]   w_head_instr;

    assign w_run        = (r_state == c_ST_RUN);
    assign w_redirect   = w_run && redirect_valid;
    assign w_misaligned = is_misaligned(64'(redirect_target), ALIGN_BITS);

    assign w_head_pc    = w_head[c_ENTRY_W-1:INSTR_W];
    assign w_head_instr = w_head[INSTR_W-1:0];

    assign w_out_valid  = w_run && (w_count != 2'd0);
    assign w_pop        = w_out_valid && bus.out_ready;

    // Entries held plus the one in flight, minus the one leaving this cycle;
    // keeping this below two guarantees the buffer never overflows.
    assign w_occupancy  = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue      = w_run && !redirect_valid && (w_occupancy < 3'd2);

    // A redirect drops the response arriving this cycle.
    assign w_push       = r_inflight && !w_redirect;

    fetch_skid_buffer #(
        .WIDTH (c_ENTRY_W)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data ({r_inflight_pc, bus.imem_rdata}),
        .pop       (w_pop),
        .flush     (w_redirect),
        .count     (w_count),
        .head      (w_head)
    );

    // Control FSM: one idle boot cycle, then run until a misaligned redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_BOOT;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                c_ST_BOOT: r_state <= c_ST_RUN;
                c_ST_RUN: begin
                    if (w_redirect && w_misaligned) begin
                        r_state <= c_ST_FAULT;
                        r_fault <= 1'b1;
                    end
                end
                c_ST_FAULT: r_state <= c_ST_FAULT;
                default:    r_state <= c_ST_BOOT;
            endcase
        end
    end

    // Program counter: aligned redirect beats sequential advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= initial_address;
        end else if (w_redirect && !w_misaligned) begin
            r_pc <= redirect_target;
        end else if (w_issue) begin
            r_pc <= r_pc + XLEN'(PC_STEP);
        end
    end

    // Track the outstanding request so its response is tagged with its PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    // Consumed-instruction and back-pressure cycle counters, wrapping freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_out_valid && !bus.out_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

    assign bus.imem_req        = w_issue;
    assign bus.imem_addr       = r_pc;
    assign bus.out_valid       = w_out_valid;
    assign bus.out_pc          = w_out_valid ? w_head_pc : '0;
    assign bus.out_instruction = w_out_valid ? w_head_instr : '0;
    assign fault               = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage with an
//               in-order scoreboard of issued fetches.
// Revision    : 1.0 - initial parametrised fetch stage
// ============================================================================
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] initial_address;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fault;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_stage_if #(.XLEN(32), .INSTR_W(32)) bus ();

    fetch_stage #(
        .XLEN       (32),
        .INSTR_W    (32),
        .PC_STEP    (4),
        .ALIGN_BITS (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .initial_address (initial_address),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fault           (fault),
`ifdef FETCH_PERF_EN
        .perf_fetched    (perf_fetched),
        .perf_stall      (perf_stall),
`endif
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_pops   = 0;
    logic         sb_en    = 1'b0;
    logic [31:0]  exp_pc   = 32'h0;
    logic         last_req = 1'b0;
    logic [31:0]  last_addr = 32'h0;
    fetch_entry_t sb_q[$];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle sample: record the memory request and run the scoreboard.
    task automatic half();
        fetch_entry_t e;
        @(negedge clk);
        last_req  = bus.imem_req;
        last_addr = bus.imem_addr;
        if (sb_en) begin
            if (redirect_valid) chk("req_during_redirect", 64'(bus.imem_req), 64'd0);
            if (bus.imem_req) begin
                chk("imem_addr", 64'(bus.imem_addr), 64'(exp_pc));
                e.pc    = exp_pc;
                e.instr = mem_fn(exp_pc);
                sb_q.push_back(e);
                exp_pc  = exp_pc + 32'd4;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                assert (sb_q.size() > 0) else begin
                    n_errors++;
                    $error("FAIL sb_underflow: observed out_pc=%0h expected no output", bus.out_pc);
                end
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("out_pc", 64'(bus.out_pc), 64'(e.pc));
                    chk("out_instruction", 64'(bus.out_instruction), 64'(e.instr));
                    n_pops++;
                end
            end
            if (redirect_valid) begin
                sb_q.delete();
                if (redirect_target[1:0] == 2'b00) exp_pc = redirect_target;
            end
        end
    endtask

    // Clock edge; memory answers the request sampled in the previous half.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.imem_rdata = last_req ? mem_fn(last_addr) : 32'h0;
    endtask

    task automatic do_reset(input logic [31:0] addr);
        sb_en           = 1'b0;
        reset           = 1'b1;
        initial_address = addr;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        bus.out_ready   = 1'b1;
        half(); tick();
        half();
        chk("rst_imem_req", 64'(bus.imem_req), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
        chk("rst_out_instr", 64'(bus.out_instruction), 64'd0);
        tick();
        reset  = 1'b0;
        sb_q.delete();
        exp_pc = addr;
        n_pops = 0;
        sb_en  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_rdata = 32'h0;

        // ---- Sequential fetch from 0x100 with latency checks ----
        do_reset(32'h100);
        half(); chk("boot_req", 64'(bus.imem_req), 64'd0); chk("boot_valid", 64'(bus.out_valid), 64'd0); tick();
        half(); chk("c1_req", 64'(bus.imem_req), 64'd1); chk("c1_valid", 64'(bus.out_valid), 64'd0); tick();
        half(); chk("c2_req", 64'(bus.imem_req), 64'd1); chk("c2_valid", 64'(bus.out_valid), 64'd0); tick();
        for (int i = 0; i < 4; i++) begin
            half(); chk("stream_valid", 64'(bus.out_valid), 64'd1); tick();
        end
        chk("stream_pops", 64'(n_pops), 64'd4);

        // ---- Back-pressure ----
        do_reset(32'h100);
        for (int i = 0; i < 3; i++) begin half(); tick(); end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            half();
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_pc_stable", 64'(bus.out_pc), 64'h100);
            chk("bp_req_low", 64'(bus.imem_req), 64'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            half(); chk("bp_release_valid", 64'(bus.out_valid), 64'd1); tick();
        end
        chk("bp_pops", 64'(n_pops), 64'd3);

        // ---- Redirect with buffered entry and one in flight ----
        do_reset(32'h100);
        for (int i = 0; i < 4; i++) begin half(); tick(); end
        bus.out_ready   = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        half(); chk("rd_held_pc", 64'(bus.out_pc), 64'h104); tick();
        redirect_valid  = 1'b0;
        bus.out_ready   = 1'b1;
        half(); chk("rd_flushed", 64'(bus.out_valid), 64'd0); chk("rd_req", 64'(bus.imem_req), 64'd1); tick();
        half(); chk("rd_gap", 64'(bus.out_valid), 64'd0); tick();
        half(); chk("rd_first_valid", 64'(bus.out_valid), 64'd1); chk("rd_first_pc", 64'(bus.out_pc), 64'h200); tick();

        // Redirect coinciding with a pop: popped entry is consumed.
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        half(); chk("rdpop_pc", 64'(bus.out_pc), 64'h204); tick();
        redirect_valid  = 1'b0;
        half(); chk("rdpop_gap1", 64'(bus.out_valid), 64'd0); tick();
        half(); chk("rdpop_gap2", 64'(bus.out_valid), 64'd0); tick();
        half(); chk("rdpop_pc_300", 64'(bus.out_pc), 64'h300); tick();

        // ---- Misaligned redirect ----
        redirect_valid  = 1'b1;
        redirect_target = 32'h202;
        half(); tick();
        redirect_valid  = 1'b0;
        sb_en           = 1'b0;
        half();
        chk("flt_fault", 64'(fault), 64'd1);
        chk("flt_valid", 64'(bus.out_valid), 64'd0);
        chk("flt_req", 64'(bus.imem_req), 64'd0);
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        half(); chk("flt_ignore_req", 64'(bus.imem_req), 64'd0); tick();
        redirect_valid  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            half();
            chk("flt_sticky", 64'(fault), 64'd1);
            chk("flt_req_after", 64'(bus.imem_req), 64'd0);
            chk("flt_valid_after", 64'(bus.out_valid), 64'd0);
            tick();
        end

        // ---- PC wrap ----
        do_reset(32'hFFFF_FFFC);
        half(); tick();
        half(); chk("wrap_addr0", 64'(bus.imem_addr), 64'hFFFF_FFFC); chk("wrap_req0", 64'(bus.imem_req), 64'd1); tick();
        half(); chk("wrap_addr1", 64'(bus.imem_addr), 64'h0); chk("wrap_req1", 64'(bus.imem_req), 64'd1); tick();
        for (int i = 0; i < 2; i++) begin half(); tick(); end
        chk("wrap_pops", 64'(n_pops), 64'd2);

`ifdef FETCH_PERF_EN
        // ---- Performance counters ----
        do_reset(32'h400);
        half(); chk("perf_rst_fetched", 64'(perf_fetched), 64'd0); chk("perf_rst_stall", 64'(perf_stall), 64'd0); tick();
        for (int i = 1; i < 8; i++) begin half(); tick(); end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin half(); tick(); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin half(); tick(); end
        half();
        chk("perf_fetched", 64'(perf_fetched), 64'd10);
        chk("perf_stall", 64'(perf_stall), 64'd3);
        tick();
        do_reset(32'h400);
        half(); chk("perf_clr_fetched", 64'(perf_fetched), 64'd0); chk("perf_clr_stall", 64'(perf_stall), 64'd0); tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
